// File: rtl/axis_mult_arbiter.sv
// Packet-granular round-robin arbiter sharing one AXI-Stream sample multiplier
// among NUM_CH streams; tags beats with latched weight and channel, with a beat watchdog.
module axis_mult_arbiter #(
   parameter int SDATA_WIDTH  = 128,
   parameter int WEIGHT_WIDTH = 8,
   parameter int NUM_CH       = 4,
   parameter int CH_W         = $clog2(NUM_CH),
   parameter int MAX_BEATS    = 256
) (
   input  logic                           CLK,
   input  logic                           resetn,
   input  logic [NUM_CH-1:0]              s_axis_tvalid,
   output logic [NUM_CH-1:0]              s_axis_tready,
   input  logic [NUM_CH*SDATA_WIDTH-1:0]  s_axis_tdata,
   input  logic [NUM_CH-1:0]              s_axis_tlast,
   input  logic [NUM_CH*WEIGHT_WIDTH-1:0] cfg_weight,
   output logic                           m_axis_tvalid,
   input  logic                           m_axis_tready,
   output logic [SDATA_WIDTH-1:0]         m_axis_tdata,
   output logic                           m_axis_tlast,
   output logic [CH_W-1:0]                m_axis_tdest,
   output logic [WEIGHT_WIDTH-1:0]        m_weight,
   output logic                           err_trunc,
   output logic [CH_W-1:0]                err_chan
);

   localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                  state, state_nxt;
   logic [CH_W-1:0]         rr_ptr, grant, winner, grant_inc, idx;
   logic                    found;
   logic [WEIGHT_WIDTH-1:0] wgt_q;
   logic [CNT_W-1:0]        beat_cnt;
   logic                    out_free, accept, beat_last, wd_hit;

   assign out_free  = !m_axis_tvalid || m_axis_tready;
   assign accept    = (state == LOCKED) && s_axis_tvalid[grant] && out_free;
   assign beat_last = s_axis_tlast[grant];
   assign wd_hit    = (beat_cnt == CNT_W'(MAX_BEATS - 1));
   assign grant_inc = (int'(grant) == NUM_CH - 1) ? '0 : grant + 1'b1;

   // Round-robin search: first valid channel at or after rr_ptr, wrapping.
   always_comb begin
      // NOTE: every variable written here gets a default first so no latch is inferred.
      found  = 1'b0;
      winner = '0;
      idx    = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         idx = CH_W'((int'(rr_ptr) + i) % NUM_CH);
         if (!found && s_axis_tvalid[idx]) begin
            found  = 1'b1;
            winner = idx;
         end
      end
   end

   always_ff @(posedge CLK or negedge resetn) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      if (!resetn) state <= IDLE;
      else         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      s_axis_tready = '0;
      case (state)
         IDLE: begin
            if (found) state_nxt = LOCKED;
         end
         LOCKED: begin
            s_axis_tready[grant] = out_free;
            if (accept && (beat_last || wd_hit)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         rr_ptr   <= '0;
         grant    <= '0;
         wgt_q    <= '0;
         beat_cnt <= '0;
      end else begin
         if (state == IDLE && found) begin
            grant    <= winner;
            wgt_q    <= cfg_weight[int'(winner)*WEIGHT_WIDTH +: WEIGHT_WIDTH];
            beat_cnt <= '0;
         end
         if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_last || wd_hit) rr_ptr <= grant_inc;
         end
      end
   end

   // Output stage holds everything while the multiplier stalls.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdest  <= '0;
         m_weight      <= '0;
      end else if (accept) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= s_axis_tdata[int'(grant)*SDATA_WIDTH +: SDATA_WIDTH];
         m_axis_tlast  <= beat_last || wd_hit;
         m_axis_tdest  <= grant;
         m_weight      <= wgt_q;
      end else if (out_free) begin
         m_axis_tvalid <= 1'b0;
      end
   end

   // A watchdog hit coinciding with the real tlast is a normal termination.
   always_ff @(posedge CLK or negedge resetn) begin
      if (!resetn) begin
         err_trunc <= 1'b0;
         err_chan  <= '0;
      end else if (accept && wd_hit && !beat_last) begin
         err_trunc <= 1'b1;
         if (!err_trunc) err_chan <= grant;
      end
   end

endmodule

// File: tb/tb_axis_mult_arbiter.sv
// Directed bench for axis_mult_arbiter: a default instance plus one with a
// 4-beat watchdog, sharing stimulus; each task checks one feature inline.
module tb_axis_mult_arbiter;

   localparam int SW  = 128;
   localparam int WW  = 8;
   localparam int NCH = 4;
   localparam int CHW = 2;

   typedef struct {
      logic [CHW-1:0] ch;
      logic [SW-1:0]  data;
      logic           last;
   } src_t;

   typedef struct {
      logic [SW-1:0]  data;
      logic           last;
      logic [CHW-1:0] dest;
      logic [WW-1:0]  wgt;
      int             cyc;
   } out_t;

   logic                CLK = 1'b0;
   logic                resetn;
   logic [NCH-1:0]      s_tvalid, s_tlast;
   logic [NCH*SW-1:0]   s_tdata;
   logic [NCH*WW-1:0]   cfg_weight;
   logic                m_tready;

   logic [NCH-1:0]      d_s_tready, w_s_tready, o_s_tready;
   logic                d_m_tvalid, w_m_tvalid, o_m_tvalid;
   logic [SW-1:0]       d_m_tdata, w_m_tdata, o_m_tdata;
   logic                d_m_tlast, w_m_tlast, o_m_tlast;
   logic [CHW-1:0]      d_m_tdest, w_m_tdest, o_m_tdest;
   logic [WW-1:0]       d_m_weight, w_m_weight, o_m_weight;
   logic                d_err_trunc, w_err_trunc;
   logic [CHW-1:0]      d_err_chan, w_err_chan;
   logic                use_wd;

   int   checks = 0;
   int   errors = 0;
   src_t src_q[$];
   out_t out_q[$];
   int   first_in, first_out, tready_viol, stab_viol, stall_cnt;
   int   acc_cnt[NCH];
   int   rdy_mode;
   bit   wchg_en;

   always #5 CLK = ~CLK;

   axis_mult_arbiter u_dut (
      .CLK(CLK), .resetn(resetn),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(d_s_tready), .s_axis_tdata(s_tdata),
      .s_axis_tlast(s_tlast), .cfg_weight(cfg_weight),
      .m_axis_tvalid(d_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(d_m_tdata),
      .m_axis_tlast(d_m_tlast), .m_axis_tdest(d_m_tdest), .m_weight(d_m_weight),
      .err_trunc(d_err_trunc), .err_chan(d_err_chan)
   );

   axis_mult_arbiter #(.MAX_BEATS(4)) u_dut_wd (
      .CLK(CLK), .resetn(resetn),
      .s_axis_tvalid(s_tvalid), .s_axis_tready(w_s_tready), .s_axis_tdata(s_tdata),
      .s_axis_tlast(s_tlast), .cfg_weight(cfg_weight),
      .m_axis_tvalid(w_m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(w_m_tdata),
      .m_axis_tlast(w_m_tlast), .m_axis_tdest(w_m_tdest), .m_weight(w_m_weight),
      .err_trunc(w_err_trunc), .err_chan(w_err_chan)
   );

   assign o_s_tready = use_wd ? w_s_tready : d_s_tready;
   assign o_m_tvalid = use_wd ? w_m_tvalid : d_m_tvalid;
   assign o_m_tdata  = use_wd ? w_m_tdata  : d_m_tdata;
   assign o_m_tlast  = use_wd ? w_m_tlast  : d_m_tlast;
   assign o_m_tdest  = use_wd ? w_m_tdest  : d_m_tdest;
   assign o_m_weight = use_wd ? w_m_weight : d_m_weight;

   function automatic logic [SW-1:0] mk(input int ch, input int i);
      logic [SW-1:0] d;
      d          = '0;
      d[7:0]     = 8'(i);
      d[71:64]   = 8'(i * 3 + ch);
      d[127:120] = 8'(ch);
      return d;
   endfunction

   task automatic push_pkt(input int ch, input int first, input int n);
      src_t s;
      for (int i = first; i < first + n; i++) begin
         s.ch   = CHW'(ch);
         s.data = mk(ch, i);
         s.last = (i == first + n - 1);
         src_q.push_back(s);
      end
   endtask

   task automatic apply_inputs(input int k);
      bit got;
      s_tvalid = '0;
      s_tlast  = '0;
      for (int c = 0; c < NCH; c++) begin
         got = 1'b0;
         for (int j = 0; j < src_q.size(); j++) begin
            if (!got && int'(src_q[j].ch) == c) begin
               got               = 1'b1;
               s_tvalid[c]       = 1'b1;
               s_tdata[c*SW +: SW] = src_q[j].data;
               s_tlast[c]        = src_q[j].last;
            end
         end
      end
      m_tready = (rdy_mode == 0) ? 1'b1 : (k % 2 == 0);
   endtask

   task automatic do_reset();
      resetn   = 1'b0;
      s_tvalid = '0;
      s_tlast  = '0;
      s_tdata  = '0;
      m_tready = 1'b0;
      use_wd   = 1'b0;
      rdy_mode = 0;
      wchg_en  = 1'b0;
      src_q.delete();
      out_q.delete();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      resetn = 1'b1;
      @(posedge CLK);
      #1;
   endtask

   // Drives queued beats, samples outputs on the falling edge, stops when drained
   // (or after stop_outs output beats, returning at that falling edge).
   task automatic run_traffic(input int max_cyc, input int stop_outs);
      bit             done, stall_prev, bit_ok;
      logic [NCH-1:0] acc;
      out_t           o, prev;
      done = 1'b0; stall_prev = 1'b0;
      first_in = -1; first_out = -1;
      tready_viol = 0; stab_viol = 0; stall_cnt = 0;
      for (int c = 0; c < NCH; c++) acc_cnt[c] = 0;
      apply_inputs(0);
      for (int k = 0; k < max_cyc && !done; k++) begin
         @(negedge CLK);
         o.data = o_m_tdata; o.last = o_m_tlast; o.dest = o_m_tdest;
         o.wgt  = o_m_weight; o.cyc = k;
         if (o_m_tvalid && m_tready) out_q.push_back(o);
         if (!$onehot0(o_s_tready)) tready_viol++;
         if (stall_prev && (!o_m_tvalid || o.data !== prev.data || o.last !== prev.last ||
                            o.dest !== prev.dest || o.wgt !== prev.wgt)) stab_viol++;
         stall_prev = o_m_tvalid && !m_tready;
         if (stall_prev) stall_cnt++;
         prev = o;
         if (first_in < 0 && |s_tvalid) first_in = k;
         if (first_out < 0 && o_m_tvalid) first_out = k;
         acc = s_tvalid & o_s_tready;
         if (stop_outs > 0 && out_q.size() >= stop_outs) done = 1'b1;
         else if (src_q.size() == 0 && !o_m_tvalid) done = 1'b1;
         else begin
            @(posedge CLK);
            #1;
            for (int c = 0; c < NCH; c++) begin
               if (acc[c]) begin
                  acc_cnt[c]++;
                  bit_ok = 1'b0;
                  for (int j = 0; j < src_q.size(); j++) begin
                     if (!bit_ok && int'(src_q[j].ch) == c) begin
                        bit_ok = 1'b1;
                        src_q.delete(j);
                     end
                  end
               end
            end
            if (wchg_en && acc_cnt[3] == 2) cfg_weight[3*WW +: WW] = 8'h20;
            apply_inputs(k + 1);
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL run_timeout: traffic not drained after %0d cycles, %0d beats left", max_cyc, src_q.size());
      end
   endtask

   task automatic test_reset();
      resetn   = 1'b0;
      s_tvalid = '1;
      s_tlast  = '0;
      s_tdata  = '1;
      m_tready = 1'b1;
      use_wd   = 1'b0;
      cfg_weight = '1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      checks++;
      if ({d_m_tvalid, d_m_tlast, d_m_tdest, d_m_weight, d_s_tready} !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got valid=%b last=%b dest=%0d wgt=%h tready=%b expected all 0",
                  d_m_tvalid, d_m_tlast, d_m_tdest, d_m_weight, d_s_tready);
      end
      checks++;
      if (d_m_tdata !== '0) begin
         errors++;
         $display("FAIL reset_tdata: got %h expected 0", d_m_tdata);
      end
      checks++;
      if ({d_err_trunc, d_err_chan, w_err_trunc, w_err_chan, w_s_tready} !== '0) begin
         errors++;
         $display("FAIL reset_err: got trunc=%b chan=%0d wd_trunc=%b wd_chan=%0d wd_tready=%b expected 0",
                  d_err_trunc, d_err_chan, w_err_trunc, w_err_chan, w_s_tready);
      end
      do_reset();
      @(negedge CLK);
      checks++;
      if ({d_m_tvalid, d_s_tready} !== '0) begin
         errors++;
         $display("FAIL reset_idle: got valid=%b tready=%b expected 0", d_m_tvalid, d_s_tready);
      end
   endtask

   task automatic test_single();
      do_reset();
      cfg_weight = {8'h10, 8'h33, 8'h40, 8'h11};
      push_pkt(1, 0, 4);
      run_traffic(100, 0);
      checks++;
      if (out_q.size() != 4) begin
         errors++;
         $display("FAIL single_count: got %0d beats expected 4", out_q.size());
      end
      for (int i = 0; i < out_q.size() && i < 4; i++) begin
         checks++;
         if (out_q[i].data !== mk(1, i) || out_q[i].dest !== 2'd1 || out_q[i].wgt !== 8'h40 ||
             out_q[i].last !== (i == 3)) begin
            errors++;
            $display("FAIL single_beat[%0d]: got data=%h dest=%0d wgt=%h last=%b expected data=%h dest=1 wgt=40 last=%b",
                     i, out_q[i].data, out_q[i].dest, out_q[i].wgt, out_q[i].last, mk(1, i), (i == 3));
         end
      end
      checks++;
      if (first_out - first_in != 2) begin
         errors++;
         $display("FAIL single_latency: got %0d cycles expected 2", first_out - first_in);
      end
   endtask

   task automatic test_round_robin();
      int         exp_ch[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
      int         exp_i[10]  = '{0, 1, 0, 1, 0, 1, 0, 1, 2, 3};
      logic [7:0] wtab[4]    = '{8'h11, 8'h40, 8'h33, 8'h10};
      do_reset();
      cfg_weight = {8'h10, 8'h33, 8'h40, 8'h11};
      push_pkt(0, 0, 2);
      push_pkt(1, 0, 2);
      push_pkt(2, 0, 2);
      push_pkt(3, 0, 2);
      push_pkt(0, 2, 2);
      run_traffic(200, 0);
      checks++;
      if (out_q.size() != 10) begin
         errors++;
         $display("FAIL rr_count: got %0d beats expected 10", out_q.size());
      end
      for (int i = 0; i < out_q.size() && i < 10; i++) begin
         checks++;
         if (out_q[i].data !== mk(exp_ch[i], exp_i[i]) || int'(out_q[i].dest) != exp_ch[i] ||
             out_q[i].wgt !== wtab[exp_ch[i]] || out_q[i].last !== (i % 2 == 1)) begin
            errors++;
            $display("FAIL rr_beat[%0d]: got dest=%0d wgt=%h last=%b data=%h expected dest=%0d wgt=%h last=%b data=%h",
                     i, out_q[i].dest, out_q[i].wgt, out_q[i].last, out_q[i].data,
                     exp_ch[i], wtab[exp_ch[i]], (i % 2 == 1), mk(exp_ch[i], exp_i[i]));
         end
         if (i > 0) begin
            checks++;
            if (out_q[i].cyc - out_q[i-1].cyc != ((i % 2 == 0) ? 2 : 1)) begin
               errors++;
               $display("FAIL rr_gap[%0d]: got %0d cycles expected %0d",
                        i, out_q[i].cyc - out_q[i-1].cyc, (i % 2 == 0) ? 2 : 1);
            end
         end
      end
      checks++;
      if (tready_viol != 0) begin
         errors++;
         $display("FAIL rr_tready_onehot: got %0d cycles with multiple tready expected 0", tready_viol);
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      cfg_weight = {8'h10, 8'h33, 8'h40, 8'h11};
      rdy_mode = 1;
      push_pkt(2, 0, 8);
      run_traffic(200, 0);
      checks++;
      if (out_q.size() != 8) begin
         errors++;
         $display("FAIL bp_count: got %0d beats expected 8", out_q.size());
      end
      for (int i = 0; i < out_q.size() && i < 8; i++) begin
         checks++;
         if (out_q[i].data !== mk(2, i) || out_q[i].dest !== 2'd2 || out_q[i].wgt !== 8'h33 ||
             out_q[i].last !== (i == 7)) begin
            errors++;
            $display("FAIL bp_beat[%0d]: got data=%h dest=%0d wgt=%h last=%b expected data=%h dest=2 wgt=33 last=%b",
                     i, out_q[i].data, out_q[i].dest, out_q[i].wgt, out_q[i].last, mk(2, i), (i == 7));
         end
      end
      checks++;
      if (stab_viol != 0 || stall_cnt == 0) begin
         errors++;
         $display("FAIL bp_stable: got %0d unstable stalls over %0d stalls expected 0 unstable and some stalls",
                  stab_viol, stall_cnt);
      end
   endtask

   task automatic test_weight_change();
      do_reset();
      cfg_weight = {8'h10, 8'h33, 8'h40, 8'h11};
      wchg_en = 1'b1;
      push_pkt(3, 0, 5);
      push_pkt(3, 5, 2);
      run_traffic(200, 0);
      checks++;
      if (out_q.size() != 7) begin
         errors++;
         $display("FAIL wgt_count: got %0d beats expected 7", out_q.size());
      end
      for (int i = 0; i < out_q.size() && i < 7; i++) begin
         checks++;
         if (out_q[i].wgt !== ((i < 5) ? 8'h10 : 8'h20) || out_q[i].data !== mk(3, i) ||
             out_q[i].last !== (i == 4 || i == 6)) begin
            errors++;
            $display("FAIL wgt_beat[%0d]: got wgt=%h last=%b data=%h expected wgt=%h last=%b data=%h",
                     i, out_q[i].wgt, out_q[i].last, out_q[i].data,
                     (i < 5) ? 8'h10 : 8'h20, (i == 4 || i == 6), mk(3, i));
         end
      end
   endtask

   task automatic test_watchdog();
      do_reset();
      use_wd = 1'b1;
      cfg_weight = {8'h10, 8'h33, 8'h40, 8'h11};
      push_pkt(0, 0, 6);
      run_traffic(200, 0);
      checks++;
      if (out_q.size() != 6) begin
         errors++;
         $display("FAIL wd_count: got %0d beats expected 6", out_q.size());
      end
      for (int i = 0; i < out_q.size() && i < 6; i++) begin
         checks++;
         if (out_q[i].data !== mk(0, i) || out_q[i].dest !== 2'd0 || out_q[i].last !== (i == 3 || i == 5)) begin
            errors++;
            $display("FAIL wd_beat[%0d]: got data=%h dest=%0d last=%b expected data=%h dest=0 last=%b",
                     i, out_q[i].data, out_q[i].dest, out_q[i].last, mk(0, i), (i == 3 || i == 5));
         end
      end
      checks++;
      if (out_q.size() == 6 && out_q[4].cyc - out_q[3].cyc != 2) begin
         errors++;
         $display("FAIL wd_rearb_gap: got %0d cycles expected 2", out_q[4].cyc - out_q[3].cyc);
      end
      checks++;
      if (w_err_trunc !== 1'b1 || w_err_chan !== 2'd0) begin
         errors++;
         $display("FAIL wd_err_ch0: got trunc=%b chan=%0d expected trunc=1 chan=0", w_err_trunc, w_err_chan);
      end

      do_reset();
      use_wd = 1'b1;
      push_pkt(1, 0, 5);
      run_traffic(200, 0);
      checks++;
      if (w_err_trunc !== 1'b1 || w_err_chan !== 2'd1) begin
         errors++;
         $display("FAIL wd_err_ch1: got trunc=%b chan=%0d expected trunc=1 chan=1", w_err_trunc, w_err_chan);
      end
      out_q.delete();
      push_pkt(2, 0, 5);
      run_traffic(200, 0);
      checks++;
      if (out_q.size() != 5 || out_q[3].last !== 1'b1 || out_q[3].dest !== 2'd2) begin
         errors++;
         $display("FAIL wd_ch2_forced: got %0d beats expected 5 with forced tlast on ch2 beat 4", out_q.size());
      end
      checks++;
      if (w_err_trunc !== 1'b1 || w_err_chan !== 2'd1) begin
         errors++;
         $display("FAIL wd_err_sticky: got trunc=%b chan=%0d expected trunc=1 chan=1", w_err_trunc, w_err_chan);
      end

      do_reset();
      use_wd = 1'b1;
      push_pkt(0, 0, 4);
      run_traffic(200, 0);
      checks++;
      if (w_err_trunc !== 1'b0 || out_q.size() != 4 || out_q[3].last !== 1'b1 || out_q[2].last !== 1'b0) begin
         errors++;
         $display("FAIL wd_exact_len: got trunc=%b beats=%0d expected trunc=0 beats=4 tlast on beat 4 only",
                  w_err_trunc, out_q.size());
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      cfg_weight = {8'h10, 8'h33, 8'h40, 8'h11};
      push_pkt(1, 0, 6);
      run_traffic(100, 2);
      checks++;
      if (d_m_tvalid !== 1'b1) begin
         errors++;
         $display("FAIL areset_pre: got m_tvalid=%b expected 1 mid-packet", d_m_tvalid);
      end
      resetn = 1'b0;
      #1;
      checks++;
      if ({d_m_tvalid, d_m_tlast, d_m_tdest, d_m_weight, d_s_tready, d_err_trunc, d_err_chan} !== '0 ||
          d_m_tdata !== '0) begin
         errors++;
         $display("FAIL areset_outputs: got valid=%b last=%b dest=%0d wgt=%h tready=%b data=%h expected all 0",
                  d_m_tvalid, d_m_tlast, d_m_tdest, d_m_weight, d_s_tready, d_m_tdata);
      end
      src_q.delete();
      out_q.delete();
      s_tvalid = '0;
      s_tlast  = '0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      resetn = 1'b1;
      @(posedge CLK);
      #1;
      push_pkt(2, 0, 3);
      run_traffic(100, 0);
      checks++;
      if (out_q.size() != 3 || out_q[0].dest !== 2'd2 || out_q[0].data !== mk(2, 0) || out_q[2].last !== 1'b1) begin
         errors++;
         $display("FAIL areset_regrant: got %0d beats first dest=%0d expected 3 beats first dest=2",
                  out_q.size(), (out_q.size() > 0) ? int'(out_q[0].dest) : -1);
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_round_robin();
      test_backpressure();
      test_weight_change();
      test_watchdog();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not complete in time");
      $fatal(1, "simulation time limit reached");
   end

endmodule
